// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator running on the system clock.
// An internal divider produces the pixel tick; raw h/v counters feed a PIPE_DLY-deep
// tick-shifted delay line, and a final register stage drives every output pin.
// Optional feature macro: VGA_FRAME_CNT_EN adds the 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Elaboration-time guards on the parameter ranges the counters can represent
  if (H_TOTAL > 1024) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL must be <= 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL must be <= 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_dly_err
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end

  localparam logic [3:0]  DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // One delay-line entry: counters plus decoded flags; syncs are kept as "active" flags
  // so a cleared entry always means inactive sync regardless of SYNC_POL.
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } stage_t;

  logic [3:0] div;
  logic       tick;
  logic [9:0] h_raw;
  logic [9:0] v_raw;
  stage_t     raw_stage;
  stage_t     out_stage;

  assign tick = (div == DIV_MAX);

  // Pixel divider: counts 0..CLK_DIV-1 and produces tick on the last count
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Raw beam position: h advances per tick, v advances when h wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      h_raw <= '0;
      v_raw <= '0;
    end else if (tick) begin
      if (h_raw == H_MAX) begin
        h_raw <= '0;
        if (v_raw == V_MAX) begin
          v_raw <= '0;
        end else begin
          v_raw <= v_raw + 10'd1;
        end
      end else begin
        h_raw <= h_raw + 10'd1;
      end
    end
  end

  // Decode the raw position into the timing flags
  always_comb begin
    raw_stage       = '0;
    raw_stage.h     = h_raw;
    raw_stage.v     = v_raw;
    raw_stage.valid = ({1'b0, h_raw} < H_ACT) && ({1'b0, v_raw} < V_ACT);
    raw_stage.hs    = ({1'b0, h_raw} >= HS_BEG) && ({1'b0, h_raw} < HS_END);
    raw_stage.vs    = ({1'b0, v_raw} >= VS_BEG) && ({1'b0, v_raw} < VS_END);
    raw_stage.ls    = (h_raw == 10'd0);
    raw_stage.fs    = (h_raw == 10'd0) && (v_raw == 10'd0);
  end

  if (PIPE_DLY == 0) begin : g_nodly
    assign out_stage = raw_stage;
  end else begin : g_dly
    stage_t pipe [PIPE_DLY];

    // Tick-driven shift register aligning timing with the downstream pixel pipeline
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= '0;
      end else if (tick) begin
        pipe[0] <= raw_stage;
        for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign out_stage = pipe[PIPE_DLY-1];
  end

  // Output register: levels load on tick, strobes are single-cycle alongside pix_en
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= tick & out_stage.ls;
      frame_start <= tick & out_stage.fs;
      if (tick) begin
        h_cnt <= out_stage.h;
        v_cnt <= out_stage.v;
        valid <= out_stage.valid;
        hsync <= out_stage.hs ? SYNC_POL : ~SYNC_POL;
        vsync <= out_stage.vs ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps together with frame_start and wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (tick && out_stage.fs) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
